// File: rtl/side_stack_bank.sv
// Multi-lane LIFO overflow store on one edge of the systolic array, with a valid/ready/ack handshake.
// Optional high-water-mark output enabled by defining SIDE_STACK_HWM_EN.
module side_stack_bank #(
  parameter int   PRECISION = 8,
  parameter int   LANES     = 8,
  parameter int   DEPTH     = 32,
  parameter logic IMAGE_SEL = 1'b0
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic                         cmd_valid,
  input  logic [2:0]                   command_to_execute,
  input  logic [1:0]                   shift_direction,
  input  logic                         image_to_shift,
  input  logic [LANES*PRECISION-1:0]   inp,
  output logic [LANES*PRECISION-1:0]   oup,
  output logic                         ready,
  input  logic                         ack,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow_err,
  output logic                         underflow_err
`ifdef SIDE_STACK_HWM_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]   hwm
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = LANES * PRECISION;

  typedef enum logic [2:0] {
    CMD_MUL    = 3'b000,
    CMD_UP     = 3'b001,
    CMD_DOWN   = 3'b010,
    CMD_LEFT   = 3'b011,
    CMD_RIGHT  = 3'b100,
    CMD_OVW_AB = 3'b101,
    CMD_OVW_S  = 3'b110,
    CMD_RESET  = 3'b111
  } cmd_e;

  typedef enum logic {
    ST_IDLE,
    ST_DONE
  } state_e;

  state_e          state_q;
  logic            ready_q;
  logic [CW-1:0]   count_q, count_d;
  logic [DW-1:0]   oup_q, oup_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            accept, img_hit, flush, do_push;
  logic [2:0]      push_cmd, pop_cmd;
  logic [AW-1:0]   wr_addr, rd_addr;
  logic [DW-1:0]   rd_data;

  // NOTE: storage array has no reset; count_q=0 already makes every entry unreachable.
  logic [PRECISION-1:0] mem_q [LANES][DEPTH];

  assign accept  = (state_q == ST_IDLE) && cmd_valid;
  assign img_hit = (image_to_shift == IMAGE_SEL);
  assign flush   = accept && ((command_to_execute == CMD_OVW_AB) ||
                              (command_to_execute == CMD_RESET));
  assign wr_addr = AW'(count_q);
  assign rd_addr = AW'(count_q - CW'(1));

  // Push is the shift toward this edge, pop the shift away from it.
  always_comb begin
    push_cmd = CMD_UP;
    pop_cmd  = CMD_DOWN;
    case (shift_direction)
      2'b00:   begin push_cmd = CMD_UP;    pop_cmd = CMD_DOWN;  end
      2'b01:   begin push_cmd = CMD_DOWN;  pop_cmd = CMD_UP;    end
      2'b10:   begin push_cmd = CMD_LEFT;  pop_cmd = CMD_RIGHT; end
      default: begin push_cmd = CMD_RIGHT; pop_cmd = CMD_LEFT;  end
    endcase
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < LANES; k++) begin
      rd_data[k*PRECISION +: PRECISION] = mem_q[k][rd_addr];
    end
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    count_d = count_q;
    oup_d   = oup_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    do_push = 1'b0;
    if (flush) begin
      count_d = '0;
      oup_d   = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else if (accept && img_hit && (command_to_execute == push_cmd)) begin
      if (count_q == CW'(DEPTH)) begin
        ovf_d = 1'b1;
      end else begin
        do_push = 1'b1;
        count_d = count_q + CW'(1);
      end
    end else if (accept && img_hit && (command_to_execute == pop_cmd)) begin
      if (count_q == '0) begin
        oup_d = '0;
        unf_d = 1'b1;
      end else begin
        oup_d   = rd_data;
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) begin
      for (int k = 0; k < LANES; k++) begin
        mem_q[k][wr_addr] <= inp[k*PRECISION +: PRECISION];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      count_q <= '0;
      oup_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      oup_q   <= oup_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            state_q <= ST_DONE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          if (ack) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef SIDE_STACK_HWM_EN
  logic [CW-1:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = hwm_q;
    if (flush) begin
      hwm_d = '0;
    end else if (count_d > hwm_q) begin
      hwm_d = count_d;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      hwm_q <= '0;
    end else begin
      hwm_q <= hwm_d;
    end
  end

  assign hwm = hwm_q;
`else
  // Without SIDE_STACK_HWM_EN no high-water tracking exists.
`endif

  assign oup           = oup_q;
  assign ready         = ready_q;
  assign count         = count_q;
  assign full          = (count_q == CW'(DEPTH));
  assign empty         = (count_q == '0);
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

endmodule

// File: tb/tb_side_stack_bank.sv
// Directed self-checking bench for side_stack_bank: LANES=4, DEPTH=4, bank on the LEFT edge.
module tb_side_stack_bank;

  localparam int P  = 8;
  localparam int L  = 4;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  localparam logic [2:0] C_MUL   = 3'b000;
  localparam logic [2:0] C_UP    = 3'b001;
  localparam logic [2:0] C_PUSH  = 3'b011;
  localparam logic [2:0] C_POP   = 3'b100;
  localparam logic [2:0] C_OVWAB = 3'b101;
  localparam logic [2:0] C_OVWS  = 3'b110;
  localparam logic [2:0] C_RST   = 3'b111;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cmd_valid = 1'b0;
  logic [2:0]      command = 3'b000;
  logic [1:0]      dir = 2'b10;
  logic            img = 1'b0;
  logic [L*P-1:0]  inp = '0;
  logic [L*P-1:0]  oup;
  logic            ready;
  logic            ack = 1'b0;
  logic [CW-1:0]   count;
  logic            full, empty, ovf, unf;
`ifdef SIDE_STACK_HWM_EN
  logic [CW-1:0]   hwm;
`endif

  int errors = 0;
  int checks = 0;

  side_stack_bank #(.PRECISION(P), .LANES(L), .DEPTH(D), .IMAGE_SEL(1'b0)) dut (
    .CLK                (clk),
    .reset              (rst),
    .cmd_valid          (cmd_valid),
    .command_to_execute (command),
    .shift_direction    (dir),
    .image_to_shift     (img),
    .inp                (inp),
    .oup                (oup),
    .ready              (ready),
    .ack                (ack),
    .count              (count),
    .full               (full),
    .empty              (empty),
    .overflow_err       (ovf),
    .underflow_err      (unf)
`ifdef SIDE_STACK_HWM_EN
    ,
    .hwm                (hwm)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] cmd, input logic im, input logic [L*P-1:0] data);
    @(negedge clk);
    cmd_valid = 1'b1;
    command   = cmd;
    img       = im;
    inp       = data;
    @(posedge clk);
    #1;
    check("ready_after_accept", {63'b0, ready}, 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic acknowledge();
    @(negedge clk);
    ack = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_ack", {63'b0, ready}, 64'd0);
    ack = 1'b0;
  endtask

  task automatic op(input logic [2:0] cmd, input logic im, input logic [L*P-1:0] data);
    issue(cmd, im, data);
    acknowledge();
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", {63'b0, empty}, 64'd1);
    check("rst_full", {63'b0, full}, 64'd0);
    check("rst_ready", {63'b0, ready}, 64'd0);
    check("rst_oup", 64'(oup), 64'd0);
    check("rst_errs", {62'b0, ovf, unf}, 64'd0);

    // Asynchronous reset while waiting in DONE
    op(C_PUSH, 1'b0, 32'hAABBCCDD);
    issue(C_POP, 1'b0, '0);
    check("pre_rst_oup", 64'(oup), 64'hAABBCCDD);
    #2 rst = 1'b1;
    #1;
    check("async_rst_ready", {63'b0, ready}, 64'd0);
    check("async_rst_oup", 64'(oup), 64'd0);
    check("async_rst_count", 64'(count), 64'd0);
    check("async_rst_empty", {63'b0, empty}, 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Basic LIFO order across lanes
    op(C_PUSH, 1'b0, 32'h04030201);
    op(C_PUSH, 1'b0, 32'h14131211);
    check("two_push_count", 64'(count), 64'd2);
    op(C_POP, 1'b0, '0);
    check("pop1_oup", 64'(oup), 64'h14131211);
    op(C_POP, 1'b0, '0);
    check("pop2_oup", 64'(oup), 64'h04030201);
    check("pop2_empty", {63'b0, empty}, 64'd1);

    // Overflow: fifth push dropped
    op(C_PUSH, 1'b0, 32'h21222324);
    op(C_PUSH, 1'b0, 32'h31323334);
    op(C_PUSH, 1'b0, 32'h41424344);
    op(C_PUSH, 1'b0, 32'h51525354);
    check("full_no_err", {63'b0, ovf}, 64'd0);
    op(C_PUSH, 1'b0, 32'h61626364);
    check("ovf_full", {63'b0, full}, 64'd1);
    check("ovf_count", 64'(count), 64'd4);
    check("ovf_err", {63'b0, ovf}, 64'd1);
    op(C_POP, 1'b0, '0);
    check("ovf_pop1", 64'(oup), 64'h51525354);
    op(C_POP, 1'b0, '0);
    check("ovf_pop2", 64'(oup), 64'h41424344);
    op(C_POP, 1'b0, '0);
    op(C_POP, 1'b0, '0);
    check("ovf_pop4", 64'(oup), 64'h21222324);

    // Underflow, then 101 flush
    op(C_POP, 1'b0, '0);
    check("unf_oup", 64'(oup), 64'd0);
    check("unf_err", {63'b0, unf}, 64'd1);
    check("unf_count", 64'(count), 64'd0);
    check("ovf_sticky", {63'b0, ovf}, 64'd1);
    op(C_OVWAB, 1'b0, '0);
    check("flush_errs", {62'b0, ovf, unf}, 64'd0);
    check("flush_count", 64'(count), 64'd0);

    // Handshake: held cmd_valid not re-executed, ack wins over cmd_valid
    @(negedge clk);
    cmd_valid = 1'b1;
    command   = C_PUSH;
    img       = 1'b0;
    inp       = 32'hC1C2C3C4;
    @(posedge clk);
    #1;
    check("hs_ready", {63'b0, ready}, 64'd1);
    check("hs_count", 64'(count), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("hs_hold_count", 64'(count), 64'd1);
    check("hs_hold_ready", {63'b0, ready}, 64'd1);
    @(negedge clk);
    ack = 1'b1;
    @(posedge clk);
    #1;
    check("hs_ack_ready", {63'b0, ready}, 64'd0);
    check("hs_ack_count", 64'(count), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_ack_ready", {63'b0, ready}, 64'd0);
    check("idle_ack_count", 64'(count), 64'd1);
    @(negedge clk);
    ack = 1'b0;
    op(C_PUSH, 1'b0, 32'hD1D2D3D4);
    op(C_POP, 1'b0, '0);
    check("hs_pop_oup", 64'(oup), 64'hD1D2D3D4);
    check("hs_pop_count", 64'(count), 64'd1);

    // No-ops: wrong image, perpendicular shift, mul, ovwS
    op(C_POP, 1'b1, '0);
    check("img_count", 64'(count), 64'd1);
    check("img_oup", 64'(oup), 64'hD1D2D3D4);
    op(C_PUSH, 1'b1, 32'hEEEEEEEE);
    check("img_push_count", 64'(count), 64'd1);
    op(C_UP, 1'b0, 32'hEEEEEEEE);
    check("perp_count", 64'(count), 64'd1);
    check("perp_oup", 64'(oup), 64'hD1D2D3D4);
    op(C_MUL, 1'b0, '0);
    op(C_OVWS, 1'b0, '0);
    check("noop_count", 64'(count), 64'd1);
    check("noop_oup", 64'(oup), 64'hD1D2D3D4);
    op(C_RST, 1'b0, '0);
    check("rstcmd_count", 64'(count), 64'd0);
    check("rstcmd_oup", 64'(oup), 64'd0);

    // Three pushes, two pops
    op(C_PUSH, 1'b0, 32'h01010101);
    op(C_PUSH, 1'b0, 32'h02020202);
    op(C_PUSH, 1'b0, 32'h03030303);
    op(C_POP, 1'b0, '0);
    op(C_POP, 1'b0, '0);
    check("hwm_seq_count", 64'(count), 64'd1);
    check("hwm_seq_oup", 64'(oup), 64'h02020202);
`ifdef SIDE_STACK_HWM_EN
    check("hwm_value", 64'(hwm), 64'd3);
    op(C_RST, 1'b0, '0);
    check("hwm_flush", 64'(hwm), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
